// File: rtl/clkdiv_ctrl_if.sv
// Divisor configuration channel: valid/ready offer of a new divisor plus a reject strobe.
interface clkdiv_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clkdiv_ctrl.sv
// Mod-N clock divider for the PWM datapath; new divisors are applied only at period
// boundaries so clk_out never emits a runt phase. tick marks the first cycle of each period.
module clkdiv_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    clkdiv_ctrl_if.slave     cfg,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] div_active,
    output logic             pending
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             err_q, err_d;

    logic             ready;
    logic             xfer;
    logic             div_ok;
    logic             wrap;

    assign ready  = (state_q != PEND);
    assign xfer   = cfg.cfg_valid && ready;
    assign div_ok = (cfg.cfg_div >= WIDTH'(2));
    assign wrap   = (cnt_q == (div_q - WIDTH'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= WIDTH'(DEFAULT_DIV);
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        pend_d  = pend_q;
        err_d   = xfer && !div_ok;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (xfer && div_ok) div_d = cfg.cfg_div;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) begin
                    // Parking: an offer accepted on this same edge goes straight into force.
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (xfer && div_ok) div_d = cfg.cfg_div;
                end else if (wrap) begin
                    cnt_d = '0;
                    if (xfer && div_ok) div_d = cfg.cfg_div;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                    if (xfer && div_ok) begin
                        pend_d  = cfg.cfg_div;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    div_d   = pend_q;
                end else if (wrap) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    div_d   = pend_q;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign clk_out       = (state_q != IDLE) && (cnt_q < (div_q >> 1));
    assign tick          = (state_q != IDLE) && (cnt_q == '0);
    assign pending       = (state_q == PEND);
    assign div_active    = div_q;
    assign cfg.cfg_ready = ready;
    assign cfg.cfg_err   = err_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Scoreboard bench for clkdiv_ctrl: stimulus queues expected tick/err events with
// hand-computed cycles; a negedge monitor pops and checks them as the DUT emits them.
module tb_clkdiv_ctrl;

    localparam int unsigned WIDTH = 16;

    typedef struct {
        int kind;   // 0 = tick, 1 = cfg_err
        int cyc;
        int div;
        int hi;
    } ev_t;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] div_active;
    logic             pending;

    int   cyc;
    int   n_cmp;
    int   n_err;
    ev_t  sb[$];
    int   hi_exp;
    int   run_len;
    logic prev_co;

    clkdiv_ctrl_if #(.WIDTH(WIDTH)) cfg_if ();

    clkdiv_ctrl #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .cfg       (cfg_if.slave),
        .clk_out   (clk_out),
        .tick      (tick),
        .div_active(div_active),
        .pending   (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int kind, input int c, input int d, input int h);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.div  = d;
        e.hi   = h;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event kind %0d at cycle %0d: got event, expected none", kind, cyc);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
            if (kind == 0) begin
                check("tick_div_active", int'(div_active), e.div);
                hi_exp  = e.hi;
                run_len = 0;
            end
        end
    endtask

    // Monitor: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hi_exp  = 0;
            run_len = 0;
            prev_co = 1'b0;
        end else begin
            if (cfg_if.cfg_err) pop_check(1);
            if (tick) pop_check(0);
            if (clk_out) begin
                run_len++;
            end else if (prev_co && hi_exp > 0) begin
                check("clk_out_high_len", run_len, hi_exp);
                hi_exp = 0;
            end
            prev_co = clk_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic offer(input int d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = WIDTH'(d);
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clk_out"},   int'(clk_out), 0);
        check({tag, "_tick"},      int'(tick), 0);
        check({tag, "_cfg_err"},   int'(cfg_if.cfg_err), 0);
        check({tag, "_pending"},   int'(pending), 0);
        check({tag, "_cfg_ready"}, int'(cfg_if.cfg_ready), 1);
        check({tag, "_div"},       int'(div_active), 10);
    endtask

    int b;
    int c2;

    initial begin
        n_cmp            = 0;
        n_err            = 0;
        hi_exp           = 0;
        run_len          = 0;
        prev_co          = 1'b0;
        rst_n            = 1'b1;
        enable           = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Default N=10: tick 1 cycle after enable, then every 10 cycles.
        b = cyc;
        push(0, b + 1, 10, 5);
        push(0, b + 11, 10, 5);
        push(0, b + 21, 10, 5);
        enable = 1'b1;

        // Offer 4 at cnt=3: pending until the wrap at b+31.
        goto(b + 24);
        check("pre_offer_ready", int'(cfg_if.cfg_ready), 1);
        push(0, b + 31, 4, 2);
        push(0, b + 35, 4, 2);
        offer(4);
        check("pend_after_accept", int'(pending), 1);
        check("ready_after_accept", int'(cfg_if.cfg_ready), 0);
        check("div_still_old", int'(div_active), 10);
        goto(b + 30);
        check("pend_before_wrap", int'(pending), 1);
        goto(b + 31);
        check("pend_after_wrap", int'(pending), 0);
        check("ready_after_wrap", int'(cfg_if.cfg_ready), 1);
        check("div_after_wrap", int'(div_active), 4);

        // Offer 6 exactly at cnt=N-1: applied at this wrap, no PEND.
        goto(b + 38);
        push(0, b + 39, 6, 3);
        push(0, b + 45, 6, 3);
        offer(6);
        check("n1_offer_pending", int'(pending), 0);
        check("n1_offer_div", int'(div_active), 6);

        // Illegal divisors 1 and 0: one cfg_err each, nothing else changes.
        goto(b + 46);
        push(1, b + 47, 0, 0);
        push(1, b + 49, 0, 0);
        push(0, b + 51, 6, 3);
        push(0, b + 57, 6, 3);
        offer(1);
        check("err1_pending", int'(pending), 0);
        goto(b + 48);
        offer(0);
        check("err0_div", int'(div_active), 6);
        check("err0_ready", int'(cfg_if.cfg_ready), 1);

        // N=3 via pending.
        goto(b + 58);
        push(0, b + 63, 3, 1);
        push(0, b + 66, 3, 1);
        push(0, b + 69, 3, 1);
        offer(3);

        // Pending 7, then disable mid-period.
        goto(b + 69);
        offer(7);
        check("pend7_pending", int'(pending), 1);
        enable = 1'b0;
        step();
        check("park_clk_out", int'(clk_out), 0);
        check("park_tick", int'(tick), 0);
        check("park_pending", int'(pending), 0);
        check("park_div", int'(div_active), 7);
        goto(b + 75);
        push(0, b + 76, 7, 3);
        push(0, b + 83, 7, 3);
        push(0, b + 90, 7, 3);
        enable = 1'b1;

        // N=2 via pending.
        goto(b + 91);
        push(0, b + 97, 2, 1);
        push(0, b + 99, 2, 1);
        push(0, b + 101, 2, 1);
        push(0, b + 103, 2, 1);
        offer(2);

        // Latch 5, then async reset mid-cycle: latched value is lost.
        goto(b + 103);
        offer(5);
        check("pend5_pending", int'(pending), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        enable = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        c2 = cyc;
        push(0, c2 + 1, 10, 5);
        push(0, c2 + 11, 10, 5);
        enable = 1'b1;
        goto(c2 + 17);
        enable = 1'b0;
        step();
        step();
        step();
        check("scoreboard_leftover", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Runtime-reconfigurable clock-divider controller for the PWM datapath. It owns the mod-N divide counter, accepts new divisor values over a valid/ready handshake, and applies each new value only at a period boundary, so `clk_out` never produces a truncated or runt phase. It also provides a one-cycle `tick` at every period start, which downstream PWM logic uses as its frame strobe.

## Interface
- `WIDTH`, 16: width of the divisor and the internal counter.
- `DEFAULT_DIV`, 10: divisor loaded at reset; must be ≥ 2 and < 2^WIDTH.

- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request; 0 stops and parks the divider.
- `cfg_valid`  in  1  new divisor offered.
- `cfg_div`  in  WIDTH  offered divisor N.
- `cfg_ready`  out  1  controller can accept a divisor this cycle.
- `cfg_err`  out  1  one-cycle pulse: the accepted divisor was < 2 and has been discarded.
- `clk_out`  out  1  divided output.
- `tick`  out  1  high for the first cycle of each period.
- `div_active`  out  WIDTH  divisor currently in force.
- `pending`  out  1  a divisor is latched and waiting for the next boundary.

## Operation
- States:
  - IDLE: `enable` = 0.
  - RUN: counting with no pending divisor.
  - PEND: counting with a latched divisor.
- Counter `cnt` runs 0..N-1, where N = `div_active`. It wraps to 0 after N-1.
- Output decode uses registers only; there is no combinational path from inputs to outputs.
  - `clk_out` = (state ≠ IDLE) && (`cnt` < N>>1). It is high for floor(N/2) cycles and low for ceil(N/2).
  - `tick` = (state ≠ IDLE) && (`cnt` == 0).
  - `cfg_ready` = (state ≠ PEND).
  - `pending` = (state == PEND).
- A transfer occurs when `cfg_valid` && `cfg_ready`.
  - If `cfg_div` < 2: the value is discarded, `cfg_err` pulses the next cycle, and state is unchanged.
  - In IDLE: the value goes to `div_active` at the next edge.
  - In RUN with `cnt` ≠ N-1: the value is latched and the state moves to PEND.
  - In RUN with `cnt` == N-1 (simultaneous with wrap): the value becomes `div_active` at this wrap. The state stays RUN, and the new period uses the new N.
- In PEND at `cnt` == N-1: `div_active` ← latched value, `cnt` ← 0, state → RUN.
- `enable` 1→0 (sampled at an edge) from RUN or PEND:
  - next state is IDLE, `cnt` ← 0;
  - a latched value is applied to `div_active` immediately;
  - the partial period is abandoned, and `clk_out`/`tick` go low next cycle.
- `enable` 0→1 in IDLE: next state is RUN with `cnt` = 0. `tick` and `clk_out` are high in the first cycle after the edge.
- Reset (async, any time):
  - state IDLE, `cnt` 0, `div_active` = DEFAULT_DIV;
  - latched value discarded;
  - `clk_out` 0, `tick` 0, `cfg_err` 0, `pending` 0, `cfg_ready` 1.
- Arithmetic: `cnt` and compares are WIDTH bits and unsigned. N-1 never underflows because N ≥ 2 is guaranteed.

## Timing
- Enable-to-first-tick latency: 1 cycle.
- Period: exactly N cycles. `tick` recurs every N cycles while `enable` = 1.
- Divisor change during run:
  - takes effect at the first wrap after acceptance, or at the accepting wrap if accepted when `cnt` == N-1;
  - the old period always completes in full.
- `cfg_ready` drops the cycle after a RUN→PEND accept. It rises the cycle after the boundary is applied.
- `cfg_err` is exactly 1 cycle wide, 1 cycle after the rejected transfer.
- `div_active` updates on the same edge that `cnt` wraps to 0 with the new N.

## Test plan
- Reset, then `enable`=1 with default N=10:
  - `tick` at cycles 1, 11, 21;
  - `clk_out` is 5 cycles high, 5 low.
- Running N=10, offer `cfg_div`=4 at `cnt`=3:
  - `pending`=1 and `cfg_ready`=0 until the wrap;
  - next period is 4 cycles, 2 high and 2 low;
  - `div_active`=4 at the wrap.
- Offer `cfg_div`=6 exactly at `cnt`=N-1: the new period starts immediately with N=6, and `pending` never asserts.
- Offer `cfg_div`=1, then `cfg_div`=0: `cfg_err` pulses once for each, and `div_active` and the period are unchanged.
- Reduced-divisor cases:
  - N=3: 1 high, 2 low.
  - N=2: 1 high, 1 low.
  - Pending N=7, then `enable`→0 mid-period: IDLE with `clk_out`=0, `div_active`=7. Re-enabling gives `tick` after 1 cycle and a 7-cycle period.
- Assert `rst_n`=0 asynchronously mid-period with a latched divisor: all outputs take their reset values immediately, `div_active`=10, and the latched value is lost.
